bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter placed in front of the Bridge data interface (Bus_addr/Bus_we/Bus_wdata/Bus_rdata).
- Master 0 is the CPU data port; master 1 is a DMA/program-loader engine.
- Round-robin ownership with a bounded burst length.
- Read data is returned to the issuing master after a fixed bridge latency; in-flight reads are tracked across ownership changes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, bridge read latency in cycles (legal 1..4).
- MAX_BURST, 8, max consecutive beats per ownership while the other master is requesting (legal 2..255).

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst  in  1  synchronous, active-low reset.
- m0_req  in  1  master 0 requests a beat.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  beat accepted this cycle (comb).
- m0_rvalid  out  1  read data for master 0 valid.
- m0_rdata  out  DW  read data for master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for master 1.
- bus_addr  out  AW  to Bridge.
- bus_we  out  1  to Bridge.
- bus_wdata  out  DW  to Bridge.
- bus_rdata  in  DW  from Bridge, valid RD_LAT cycles after the read beat.

Behaviour:
- FSM states:
  - IDLE, OWN0, OWN1.
  - last_owner register: 1 bit.
  - beat_cnt: 8 bits.
  - rd_pipe: RD_LAT entries of {valid, id}.
- Reset (cpu_rst==0 at edge):
  - state=IDLE, last_owner=1 (so m0 wins first), beat_cnt=0, rd_pipe cleared.
  - All gnt/rvalid outputs 0, bus_we=0.
  - In-flight reads are discarded; no rvalid is issued for them after reset.
- IDLE:
  - No grants.
  - If exactly one req is high, go to that OWNx.
  - If both are high, go to OWN of the master != last_owner.
  - Latency: a request seen in IDLE gets its first gnt one cycle later.
- OWNx:
  - gnt_x = req_x && !(beat_cnt==MAX_BURST && req_other).
  - gnt_other = 0.
  - Beat = req_x && gnt_x; on a beat, beat_cnt += 1 (saturating).
- Transitions from OWNx, evaluated at each edge:
  - req_x==0 and req_other==1 -> OWNother.
  - req_x==0 and req_other==0 -> IDLE.
  - beat_cnt==MAX_BURST and req_other==1 -> OWNother.
  - Otherwise stay.
  - With no contention, beat_cnt saturates and ownership persists indefinitely.
  - On any state change: beat_cnt=0 and last_owner=x.
  - OWNx->OWNother is direct: no IDLE bubble, and the other master's first gnt comes the cycle after the forced-release cycle.
- Bus drive (combinational):
  - On a beat: bus_addr = mx_addr, bus_wdata = mx_wdata, bus_we = mx_we.
  - Otherwise: bus_addr=0, bus_wdata=0, bus_we=0.
  - bus_we is never high without a grant.
- Read return:
  - A read beat (we=0) enters rd_pipe tail with {1,x}.
  - The pipe shifts every cycle.
  - At the head: mx_rvalid=1 for the tagged id, exactly RD_LAT cycles after the beat.
  - m0_rdata = m1_rdata = bus_rdata, qualified only by the respective rvalid.
  - Delivery is unaffected by later ownership switches or IDLE.
- Writes produce no rvalid.
- Masters hold req/we/addr/wdata stable until gnt; a deasserted req withdraws the beat with no side effects.
- One beat per cycle maximum; back-to-back beats from the same owner are allowed every cycle.

Test Plan:
- Reset then single read: m0_req=1, m0_we=0, m0_addr=0x10, bridge returns 0xDEADBEEF.
  -> m0_gnt high on cycle 2, bus_addr=0x10 that cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF RD_LAT cycles later, m1_rvalid stays 0.
- Simultaneous first requests: m0_req=m1_req=1 from IDLE after reset.
  -> m0 owns first.
  -> With both held, m0 gets exactly 8 beats, then m1 gets 8, alternating.
  -> No cycle has both gnt high.
- Burst cap: m1 idle, m0 holds req for 20 cycles.
  -> 20 consecutive beats, no release.
  -> m1_req rises at beat 12 -> m0 gnt drops the next cycle (beat_cnt saturated), m1 granted the following cycle.
- Read across switch (RD_LAT=3): m0 reads 0x20 on its last beat, then ownership goes to m1, which writes 0x55 to 0x30.
  -> m0_rvalid arrives 3 cycles after its beat.
  -> bus_we=1 with bus_addr=0x30, bus_wdata=0x55 on m1's beat.
  -> No m1_rvalid.
- Withdrawal: m0_req goes 1->0 while in OWN0 with m1_req=0.
  -> IDLE next cycle, bus_we=0, bus_addr=0.
  -> Next m1_req granted after 1 cycle.
- Mid-read reset: assert cpu_rst=0 one cycle after a read beat (RD_LAT=2).
  -> All outputs 0 next cycle; no rvalid ever issued for that read.
  -> After release, m0 has priority again.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the Bridge data interface.
// Master 0 is the CPU data port, master 1 the DMA/program-loader engine.
// Ownership is held while the owner keeps requesting, but is handed over
// after MAX_BURST beats if the other master is waiting. Read beats are
// tagged with the issuing master so data returns correctly across hand-overs.
module bus_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [7:0]  MB = 8'(MAX_BURST);
  localparam int unsigned L  = RD_LAT;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last_owner;
  logic [7:0]   r_beat_cnt;
  logic [L-1:0] r_rd_vld;
  logic [L-1:0] r_rd_id;

  logic w_cap;
  logic w_beat;
  logic w_beat_id;

  // Next-state selection and grant generation
  always_comb begin
    w_next    = r_state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    w_beat    = 1'b0;
    w_beat_id = 1'b0;
    w_cap     = (r_beat_cnt == MB);
    unique case (r_state)
      IDLE: begin
        if (m0_req && m1_req) w_next = r_last_owner ? OWN0 : OWN1;
        else if (m0_req)      w_next = OWN0;
        else if (m1_req)      w_next = OWN1;
      end
      OWN0: begin
        m0_gnt = m0_req && !(w_cap && m1_req);
        w_beat = m0_gnt;
        if (!m0_req)               w_next = m1_req ? OWN1 : IDLE;
        else if (w_cap && m1_req)  w_next = OWN1;
      end
      OWN1: begin
        m1_gnt    = m1_req && !(w_cap && m0_req);
        w_beat    = m1_gnt;
        w_beat_id = 1'b1;
        if (!m1_req)               w_next = m0_req ? OWN0 : IDLE;
        else if (w_cap && m0_req)  w_next = OWN0;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus drive: granted master's beat, otherwise all zeros
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (w_beat) begin
      bus_addr  = w_beat_id ? m1_addr  : m0_addr;
      bus_wdata = w_beat_id ? m1_wdata : m0_wdata;
      bus_we    = w_beat_id ? m1_we    : m0_we;
    end
  end

  // Read return: head of the tag pipe selects the receiving master
  always_comb begin
    m0_rvalid = r_rd_vld[L-1] && !r_rd_id[L-1];
    m1_rvalid = r_rd_vld[L-1] &&  r_rd_id[L-1];
    m0_rdata  = bus_rdata;
    m1_rdata  = bus_rdata;
  end

  // Ownership state, round-robin memory and burst counter
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_beat_cnt <= '0;
        if (r_state != IDLE) r_last_owner <= (r_state == OWN1);
      end else if (w_beat && (r_beat_cnt != MB)) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  // In-flight read tags shift toward the head every cycle
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      r_rd_vld <= '0;
      r_rd_id  <= '0;
    end else begin
      for (int unsigned i = 1; i < L; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_id[i]  <= r_rd_id[i-1];
      end
      r_rd_vld[0] <= w_beat && !bus_we;
      r_rd_id[0]  <= w_beat_id;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a stimulus process applies directed and
// random traffic, predicts grants/bus values and read returns from the
// arbitration rules, and queues them; a negedge monitor pops and compares.
module tb_bus_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RDL  = 3;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          cpu_rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] bus_addr;
  logic          bus_we;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RDL), .MAX_BURST(MAXB)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_val(input int c);
    return 32'hDEADBEEF ^ (32'(c) * 32'h9E37);
  endfunction

  // Bridge: read data is a known function of the cycle number
  always_comb bus_rdata = rd_val(cyc);

  typedef struct { logic g0, g1, we; logic [31:0] addr, wdata; } exp_t;
  typedef struct { int due; bit id; logic [31:0] data; } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_on = 0;

  // Reference model: owner -1 = nobody, run = beats in current ownership
  int owner = -1;
  int last  = 1;
  int run   = 0;
  bit p_r[2], p_w[2], e_g[2];
  logic [31:0] p_a[2], p_d[2];

  task automatic step(input bit rst, input bit r0, input bit w0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1,
                      input logic [31:0] a1, input logic [31:0] d1);
    exp_t e;
    bit   rq[2], g[2], capped;
    int   x, o;
    @(posedge clk); #1;
    cpu_rst = rst;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    rq[0] = r0; rq[1] = r1; g[0] = 0; g[1] = 0; capped = 0;
    x = (owner < 0) ? 0 : owner;
    o = 1 - x;
    if (owner >= 0) begin
      capped = (run == MAXB) && rq[o];
      g[x]   = rq[x] && !capped;
    end
    e.g0 = g[0]; e.g1 = g[1];
    e.we = 0; e.addr = '0; e.wdata = '0;
    if (g[0]) begin e.we = w0; e.addr = a0; e.wdata = d0; end
    if (g[1]) begin e.we = w1; e.addr = a1; e.wdata = d1; end
    exp_q.push_back(e);
    if ((g[0] || g[1]) && !e.we && rst)
      rd_q.push_back('{cyc + RDL, g[1], rd_val(cyc + RDL)});
    if (!rst) begin
      owner = -1; last = 1; run = 0;
      while (rd_q.size() > 0 && rd_q[$].due > cyc) void'(rd_q.pop_back());
    end else if (owner < 0) begin
      if (r0 && r1)  owner = 1 - last;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
      run = 0;
    end else if (!rq[x]) begin
      owner = rq[o] ? o : -1; last = x; run = 0;
    end else if (capped) begin
      owner = o; last = x; run = 0;
    end else if (g[x] && run < MAXB) begin
      run++;
    end
    p_r[0] = r0; p_w[0] = w0; p_a[0] = a0; p_d[0] = d0; e_g[0] = g[0];
    p_r[1] = r1; p_w[1] = w1; p_a[1] = a1; p_d[1] = d1; e_g[1] = g[1];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Random master: holds a pending beat, sometimes withdraws it
  task automatic rand_step();
    bit r[2], w[2]; logic [31:0] a[2], d[2]; bit rst;
    for (int m = 0; m < 2; m++) begin
      if (p_r[m] && !e_g[m]) begin
        r[m] = ($urandom_range(0, 7) != 0);
        w[m] = p_w[m]; a[m] = p_a[m]; d[m] = p_d[m];
      end else begin
        r[m] = ($urandom_range(0, 99) < 60);
        w[m] = 1'($urandom_range(0, 1));
        a[m] = $urandom & 32'h0000FFFC;
        d[m] = $urandom;
      end
    end
    rst = ($urandom_range(0, 299) != 0);
    step(rst, r[0], w[0], a[0], d[0], r[1], w[1], a[1], d[1]);
  endtask

  // Monitor: per-cycle grant/bus check and read-return check
  always @(negedge clk) begin
    if (chk_on && exp_q.size() > 0) begin
      exp_t e;
      logic [1:0] exp_rv;
      e = exp_q.pop_front();
      tests++;
      if ({m0_gnt, m1_gnt, bus_we, bus_addr, bus_wdata} !==
          {e.g0, e.g1, e.we, e.addr, e.wdata}) begin
        fails++;
        $display("FAIL gnt_bus cyc=%0d got g0=%b g1=%b we=%b a=%h d=%h want g0=%b g1=%b we=%b a=%h d=%h",
                 cyc, m0_gnt, m1_gnt, bus_we, bus_addr, bus_wdata,
                 e.g0, e.g1, e.we, e.addr, e.wdata);
      end
      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL rd_missing due=%0d got none want id=%0d", rd_q[0].due, rd_q[0].id);
        void'(rd_q.pop_front());
      end
      exp_rv = 2'b00;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) exp_rv = rd_q[0].id ? 2'b10 : 2'b01;
      tests++;
      if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
        fails++;
        $display("FAIL rvalid cyc=%0d got %b want %b", cyc, {m1_rvalid, m0_rvalid}, exp_rv);
      end else if (exp_rv != 2'b00) begin
        tests++;
        if ((rd_q[0].id ? m1_rdata : m0_rdata) !== rd_q[0].data) begin
          fails++;
          $display("FAIL rdata cyc=%0d got %h want %h", cyc,
                   rd_q[0].id ? m1_rdata : m0_rdata, rd_q[0].data);
        end
      end
      if (exp_rv != 2'b00) void'(rd_q.pop_front());
    end
  end

  initial begin
    cpu_rst = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    chk_on = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single read by m0
    step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    idle(5);
    // simultaneous requests held: alternating bursts
    for (int i = 0; i < 40; i++)
      step(1, 1, 1, 32'h100 + 32'(i), 32'(i), 1, 1, 32'h200 + 32'(i), ~32'(i));
    idle(2);
    // uncontended long burst, then m1 arrives late
    for (int i = 0; i < 24; i++)
      step(1, 1, 1, 32'h40, 32'h1234, (i >= 13), 1, 32'h44, 32'h5678);
    idle(2);
    // withdrawal then m1 request
    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h8, 32'h9, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, 32'h30, 32'h77);
    idle(2);
    // m0 reads while m1 writes: reads cross ownership switches
    for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h55);
    idle(5);
    // reset one cycle after a read beat, then both request
    step(1, 1, 0, 32'h50, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h50, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h60, 0, 1, 0, 32'h64, 0);
    idle(4);
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) rand_step();
    idle(RDL + 3);
    @(posedge clk); #1;
    tests++;
    if (rd_q.size() != 0) begin
      fails++;
      $display("FAIL rd_drain got %0d pending want 0", rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
